// File: rtl/tick_arbiter.sv
// ---------------------------------------------------------------------------
// tick_arbiter
//
// Divides time into windows of P cycles and hands each window to one of NREQ
// requesters. The owner is chosen round-robin at the window boundary and keeps
// the grant for the whole window. The period input is sampled only at a
// boundary, so it always takes effect from the next window.
//
// Parameters
//   NREQ        number of requesters
//   CNT_W       width of the period counter and of the period input
//   DEF_PERIOD  window length used after reset
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (release is synchronised inside)
//   en      advances the period counter; when low everything freezes
//   period  requested window length; 0 and 1 are treated as 2
//   req     per-requester level request
//   grant   one-hot (or zero) owner of the current window, registered
//   tick    one-cycle pulse on each window boundary, registered
//   busy    high while grant is nonzero, registered
//
// Build option
//   TICK_ARB_PRIO0_EN  when defined, req[0] wins every boundary where it is
//                      asserted; the others share round-robin among
//                      themselves, and a req[0] grant does not move the
//                      round-robin pointer.
// ---------------------------------------------------------------------------
module tick_arbiter #(
    parameter int NREQ       = 4,
    parameter int CNT_W      = 4,
    parameter int DEF_PERIOD = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  grant,
    output logic             tick,
    output logic             busy
);

    localparam int                LAST_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0]  MIN_PERIOD = CNT_W'(2);
    localparam logic [CNT_W-1:0]  DEF_P      = CNT_W'(DEF_PERIOD);
    localparam logic [LAST_W-1:0] LAST_RST   = LAST_W'(NREQ - 1);

    // ------------------------------------------------------------------
    // Reset synchroniser
    // ------------------------------------------------------------------
    // NOTE: assertion stays asynchronous, but release passes through two
    // flops so every state flop leaves reset on the same clean clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_sync_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  p_q;
    logic [CNT_W-1:0]  p_clamped;
    logic [LAST_W-1:0] last_q;
    logic [LAST_W-1:0] last_d;
    logic [NREQ-1:0]   grant_q;
    logic [NREQ-1:0]   grant_d;
    logic [NREQ-1:0]   rr_req;
    logic              tick_q;
    logic              busy_q;
    logic              wrap;

    // Window boundary: the last enabled cycle of the current window.
    assign wrap      = en && (cnt_q == (p_q - CNT_W'(1)));
    assign p_clamped = (period < MIN_PERIOD) ? MIN_PERIOD : period;

    // ------------------------------------------------------------------
    // Next-owner selection
    // ------------------------------------------------------------------
    // The search starts one past the previous owner, so a requester that
    // just held a window is considered last and only wins again when
    // nobody else is asking.
    always_comb begin
        int                idx;
        logic [LAST_W-1:0] idx_l;
        logic              found;

        // NOTE: every variable gets a default before any branch so no
        // path leaves it unassigned; that is what keeps this block from
        // inferring latches.
        grant_d = '0;
        last_d  = last_q;
        rr_req  = req;
        found   = 1'b0;
        idx     = 0;
        idx_l   = '0;

`ifdef TICK_ARB_PRIO0_EN
        // Requester 0 is handled outside the rotation.
        rr_req[0] = 1'b0;
`endif

        for (int i = 0; i < NREQ; i++) begin
            idx = int'(last_q) + 1 + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_l = LAST_W'(idx);
            if (!found && rr_req[idx_l]) begin
                found          = 1'b1;
                grant_d        = '0;
                grant_d[idx_l] = 1'b1;
                last_d         = idx_l;
            end
        end

`ifdef TICK_ARB_PRIO0_EN
        // Priority grant overrides the rotation and leaves the pointer alone.
        if (req[0]) begin
            grant_d    = '0;
            grant_d[0] = 1'b1;
            last_d     = last_q;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Counter, period, owner and pulse registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments here so every register samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            cnt_q   <= '0;
            p_q     <= DEF_P;
            grant_q <= '0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            last_q  <= LAST_RST;
        end else begin
            tick_q <= wrap;
            if (wrap) begin
                cnt_q   <= '0;
                p_q     <= p_clamped;
                grant_q <= grant_d;
                busy_q  <= |grant_d;
                last_q  <= last_d;
            end else if (en) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign grant = grant_q;
    assign tick  = tick_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_tick_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tick_arbiter
//
// Directed bench for tick_arbiter (NREQ=4, CNT_W=4, DEF_PERIOD=12). Inputs
// are driven and outputs sampled on the falling clock edge. Window lengths
// are counted in enabled state-update edges, starting at the first edge
// after the two-stage reset synchroniser has released.
// ---------------------------------------------------------------------------
module tb_tick_arbiter;

    localparam int NREQ     = 4;
    localparam int CNT_W    = 4;
    localparam int SYNC_LAT = 2;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             en     = 1'b0;
    logic [CNT_W-1:0] period = 4'd12;
    logic [NREQ-1:0]  req    = '0;
    logic [NREQ-1:0]  grant;
    logic             tick;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    tick_arbiter #(
        .NREQ       (NREQ),
        .CNT_W      (CNT_W),
        .DEF_PERIOD (12)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .period (period),
        .req    (req),
        .grant  (grant),
        .tick   (tick),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Counts falling edges until tick is seen; n = -1 if the bound expires.
    task automatic wait_tick(input int max_cycles, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < max_cycles);
        if (!tick) begin
            n = -1;
        end
    endtask

    task automatic expect_tick(input string tag, input int exp_gap, input logic [NREQ-1:0] exp_grant);
        int n;
        wait_tick(exp_gap + 4, n);
        check({tag, "_gap"},   n,     exp_gap);
        check({tag, "_grant"}, grant, exp_grant);
        check({tag, "_busy"},  busy,  |exp_grant);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        check("rst_grant", grant, 0);
        check("rst_tick",  tick,  0);
        check("rst_busy",  busy,  0);
        rst_n = 1'b1;
        repeat (SYNC_LAT) cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks_seen;
        ticks_seen = 0;

        // Idle cadence: P=12, no requests.
        en     = 1'b1;
        period = 4'd12;
        req    = 4'b0000;
        do_reset();
        expect_tick("idle1", 12, 4'b0000);
        cyc();
        check("tick_width", tick, 0);
        expect_tick("idle2", 11, 4'b0000);
        expect_tick("idle3", 12, 4'b0000);

        // Full contention, P=4 from the next window.
        period = 4'd4;
        req    = 4'b1111;
        expect_tick("rr0", 12, 4'b0001);
        cyc();
        cyc();
        check("rr_hold", grant, 4'b0001);
        expect_tick("rr1", 2, 4'b0010);
        expect_tick("rr2", 4, 4'b0100);
        expect_tick("rr3", 4, 4'b1000);
        expect_tick("rr4", 4, 4'b0001);

        // Single requester, then drop mid-window.
        req = 4'b0010;
        expect_tick("solo1", 4, 4'b0010);
        expect_tick("solo2", 4, 4'b0010);
        cyc();
        req = 4'b0000;
        cyc();
        check("solo_hold", grant, 4'b0010);
        expect_tick("solo_drop", 2, 4'b0000);

        // Period 0 clamps to 2; period change mid-window waits for the boundary.
        period = 4'd0;
        expect_tick("p0_a", 4, 4'b0000);
        expect_tick("p0_b", 2, 4'b0000);
        expect_tick("p0_c", 2, 4'b0000);
        period = 4'd12;
        expect_tick("p12", 2, 4'b0000);
        repeat (3) cyc();
        period = 4'd5;
        expect_tick("p_cur", 9, 4'b0000);
        period = 4'd12;
        req    = 4'b0100;
        expect_tick("p_next", 5, 4'b0100);

        // en low for 7 cycles at cnt=3: everything freezes.
        repeat (3) cyc();
        en = 1'b0;
        repeat (7) begin
            cyc();
            if (tick) begin
                ticks_seen++;
            end
        end
        check("freeze_tick",  ticks_seen, 0);
        check("freeze_grant", grant, 4'b0100);
        en = 1'b1;
        expect_tick("resume", 9, 4'b0100);

        // Reset pulsed at cnt=6: immediate clear, fresh 12-cycle window.
        repeat (6) cyc();
        #2 rst_n = 1'b0;
        #1;
        check("mr_grant", grant, 0);
        check("mr_tick",  tick,  0);
        check("mr_busy",  busy,  0);
        cyc();
        rst_n = 1'b1;
        repeat (SYNC_LAT) cyc();
        expect_tick("post_rst", 12, 4'b0100);

        // Mixed requests 1011 from pointer at index 2.
        period = 4'd4;
        req    = 4'b1011;
`ifdef TICK_ARB_PRIO0_EN
        expect_tick("pr0", 12, 4'b0001);
        expect_tick("pr1", 4, 4'b0001);
        req = 4'b1010;
        expect_tick("pr2", 4, 4'b1000);
        expect_tick("pr3", 4, 4'b0010);
        expect_tick("pr4", 4, 4'b1000);
`else
        expect_tick("rrb0", 12, 4'b1000);
        expect_tick("rrb1", 4, 4'b0001);
        expect_tick("rrb2", 4, 4'b0010);
        expect_tick("rrb3", 4, 4'b1000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_arbiter.md
TICK_ARBITER -- requirements
Module: tick_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing the tick window.
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the period counter.
REQ-003 The block SHALL have parameter DEF_PERIOD, default 12, giving the period loaded at reset.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: when high, the period counter advances.
REQ-007 The block SHALL have port period, input, CNT_W bits: requested window length in cycles.
REQ-008 The block SHALL have port req, input, NREQ bits: per-requester window request, level.
REQ-009 The block SHALL have port grant, output, NREQ bits: one-hot or zero owner of the current window, registered.
REQ-010 The block SHALL have port tick, output, 1 bit: single-cycle window-boundary pulse, registered.
REQ-011 The block SHALL have port busy, output, 1 bit: high while grant is nonzero.

Function
REQ-012 Counter cnt (CNT_W bits) SHALL advance by 1 per cycle with en=1 and hold its value with en=0.
REQ-013 Active period P SHALL be latched from period only on a wrap edge; values 0 and 1 SHALL clamp to P=2.
REQ-014 Wrap edge definition: en=1 and cnt==P-1. On that edge cnt<=0, tick<=1 and grant<=next owner; on every other edge tick<=0.
REQ-015 Ticks SHALL be exactly P cycles apart while en stays high; with en low, no tick occurs and the wrap is deferred.
REQ-016 Next owner SHALL be chosen round-robin from req sampled on the wrap edge. Search starts at index (last+1) mod NREQ, where last is the index of the most recent nonzero grant.
REQ-017 If req==0 on the wrap edge, grant SHALL become 0 and last SHALL be unchanged.
REQ-018 A grant SHALL persist for the whole window even if req drops mid-window; no revocation before the next wrap.
REQ-019 A requester still requesting at the wrap SHALL be re-granted only if no other requester is pending (no back-to-back windows under contention).
REQ-020 grant SHALL be one-hot or zero in every cycle.
REQ-021 When en is deasserted mid-window, cnt, grant and last SHALL freeze, and the window SHALL resume when en returns.
REQ-022 busy SHALL equal the OR-reduction of grant, registered alongside grant.
REQ-023 A change of period mid-window SHALL NOT affect the current window, only the next one.

Reset
REQ-024 rst_n=0 SHALL asynchronously force cnt=0, P=DEF_PERIOD, grant=0, tick=0, busy=0, last=NREQ-1.
REQ-025 Reset asserted mid-window SHALL abort the window with no residual tick. After release, the first tick SHALL occur P enabled cycles later.
REQ-026 Reset deassertion SHALL be synchronised internally so that the first state update occurs on a clean rising edge.

Configuration
REQ-027 Macro TICK_ARB_PRIO0_EN defined: req[0] SHALL win every wrap at which it is asserted, and round-robin SHALL apply only among the remaining requesters. last SHALL not be updated by a req[0] grant.
REQ-028 Macro TICK_ARB_PRIO0_EN undefined: pure round-robin per REQ-016, with all requesters equal.

Verification
REQ-029 period=12, en=1, req=0 after reset: ticks at cycles 12, 24, 36; grant stays 0 and busy stays 0.
REQ-030 req=4'b1111 held, P=4: grant sequence 0001, 0010, 0100, 1000, 0001, with each change coincident with tick.
REQ-031 req=4'b0010 held alone: grant=0010 on every window; after req drops mid-window, grant holds until the next tick, then becomes 0000.
REQ-032 period=0 written, then en: ticks spaced 2 cycles; period changed 12->5 mid-window: current window 12 cycles, next window 5.
REQ-033 en low for 7 cycles at cnt=3 with P=12: tick delayed exactly 7 cycles and grant unchanged; rst_n pulsed at cnt=6: grant=0 and tick=0 immediately, next tick 12 cycles after release.
REQ-034 TICK_ARB_PRIO0_EN defined, req=4'b1011 held: grant 0001 on every window; after req[0] drops, grants alternate 0010, 1000.
